// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver: oversampled start/data/parity/stop framing, LSB first
module uart_rx_core #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESC_W-1:0]    Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BIT_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t                r_state;
    logic [PRESC_W-1:0]    r_presc;
    logic [PRESC_W-1:0]    r_edge_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_bad;
    logic                  r_s0;
    logic                  r_s1;

    logic [PRESC_W-1:0]    w_presc_sel;
    logic [PRESC_W-1:0]    w_half;
    logic                  w_s0_pt;
    logic                  w_s1_pt;
    logic                  w_dec_pt;
    logic                  w_last;
    logic                  w_maj;
    logic                  w_exp_par;

    always_comb begin
        w_presc_sel = PRESC_W'(8);
        if (Prescale == PRESC_W'(16) || Prescale == PRESC_W'(32))
            w_presc_sel = Prescale;
    end

    // Third sample is the live line, so the decision lands one cycle before it is visible.
    assign w_half    = r_presc >> 1;
    assign w_s0_pt   = (r_edge_cnt == w_half - PRESC_W'(1));
    assign w_s1_pt   = (r_edge_cnt == w_half);
    assign w_dec_pt  = (r_edge_cnt == w_half + PRESC_W'(1));
    assign w_last    = (r_edge_cnt == r_presc - PRESC_W'(1));
    assign w_maj     = (r_s0 & r_s1) | (r_s0 & RX_IN) | (r_s1 & RX_IN);
    assign w_exp_par = (^r_shift) ^ r_par_typ;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_presc    <= '0;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_bad      <= 1'b0;
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            if (r_state != S_IDLE && r_state != S_WAIT_IDLE) begin
                if (w_s0_pt) r_s0 <= RX_IN;
                if (w_s1_pt) r_s1 <= RX_IN;
                r_edge_cnt <= w_last ? '0 : r_edge_cnt + PRESC_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (!RX_IN) begin
                        // The low cycle seen here is edge 0 of the start bit.
                        r_state    <= S_START;
                        r_edge_cnt <= PRESC_W'(1);
                        r_presc    <= w_presc_sel;
                        r_par_en   <= PAR_EN;
                        r_par_typ  <= PAR_TYP;
                        r_bad      <= 1'b0;
                        r_bit_cnt  <= '0;
                    end
                end
                S_START: begin
                    if (w_dec_pt && w_maj)
                        r_state <= S_IDLE;
                    else if (w_last)
                        r_state <= S_DATA;
                end
                S_DATA: begin
                    if (w_dec_pt)
                        r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
                    if (w_last) begin
                        if (r_bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (w_dec_pt && (w_maj != w_exp_par)) begin
                        par_err <= 1'b1;
                        r_bad   <= 1'b1;
                    end
                    if (w_last)
                        r_state <= S_STOP;
                end
                S_STOP: begin
                    // Leaving mid-stop-bit lets a back-to-back start edge be caught at bit end.
                    if (w_dec_pt) begin
                        if (w_maj) begin
                            if (!r_bad) begin
                                P_DATA     <= r_shift;
                                data_valid <= 1'b1;
                            end
                            r_state <= S_IDLE;
                        end else begin
                            stp_err <= 1'b1;
                            r_state <= S_WAIT_IDLE;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (RX_IN)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
